// File: rtl/cv32e40p_replica_fault_manager_if.sv
// Handshake and status bundle between the replica fault manager and the
// pipeline controller / voter.
interface cv32e40p_replica_fault_manager_if #(
  parameter int NUM_REPLICAS = 4
);
  logic                    valid_i;
  logic [NUM_REPLICAS-1:0] mismatch_i;
  logic                    reconfig_ack_i;
  logic                    reconfig_req_o;
  logic [NUM_REPLICAS-1:0] active_mask_o;
  logic [NUM_REPLICAS-1:0] permanent_faulty_o;
  logic                    degraded_o;

  modport master (
    output valid_i, mismatch_i, reconfig_ack_i,
    input  reconfig_req_o, active_mask_o, permanent_faulty_o, degraded_o
  );

  modport slave (
    input  valid_i, mismatch_i, reconfig_ack_i,
    output reconfig_req_o, active_mask_o, permanent_faulty_o, degraded_o
  );
endinterface

// File: rtl/cv32e40p_replica_fault_manager.sv
// Replica fault manager: per-replica mismatch counters, sticky fault flags and
// handshaked active-mask reconfiguration. Define CV32E40P_FAULT_DECAY_EN to let
// counters leak down on matching results.
//
// state | meaning
// IDLE  | active mask equals target, no request outstanding
// REQ   | reconfig_req_o high, waiting for reconfig_ack_i to switch the mask
module cv32e40p_replica_fault_manager #(
  parameter  int NUM_REPLICAS    = 4,
  parameter  int NUM_ACTIVE      = 3,
  parameter  int FAULT_THRESHOLD = 8,
  localparam int CNT_WIDTH       = $clog2(FAULT_THRESHOLD+1)
) (
  input logic clk,
  input logic rst,
  cv32e40p_replica_fault_manager_if.slave bus
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [CNT_WIDTH-1:0] THR = CNT_WIDTH'(FAULT_THRESHOLD);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  function automatic logic [NUM_REPLICAS-1:0] low_mask();
    logic [NUM_REPLICAS-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_ACTIVE; k++) m[k] = 1'b1;
    return m;
  endfunction

  localparam logic [NUM_REPLICAS-1:0] RST_MASK = low_mask();

  state_t                  state_q;
  logic [CNT_WIDTH-1:0]    cnt_q [NUM_REPLICAS];
  logic [CNT_WIDTH-1:0]    cnt_d [NUM_REPLICAS];
  logic [NUM_REPLICAS-1:0] faulty_q, faulty_d;
  logic [NUM_REPLICAS-1:0] mask_q, target;
  logic                    req_q, degraded_q;
  int                      n_sel, n_healthy;

  always_comb begin
    faulty_d = faulty_q;
    for (int k = 0; k < NUM_REPLICAS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (bus.valid_i && mask_q[k]) begin
        if (bus.mismatch_i[k]) begin
          if (cnt_q[k] != THR) cnt_d[k] = cnt_q[k] + ONE;
        end
`ifdef CV32E40P_FAULT_DECAY_EN
        else if (cnt_q[k] != '0) begin
          cnt_d[k] = cnt_q[k] - ONE;
        end
`endif
      end
      if (cnt_d[k] == THR) faulty_d[k] = 1'b1;
    end
  end

  // Healthy replicas first in index order, then faulty ones as padding.
  always_comb begin
    target    = '0;
    n_sel     = 0;
    n_healthy = 0;
    for (int k = 0; k < NUM_REPLICAS; k++) begin
      if (!faulty_q[k]) begin
        n_healthy = n_healthy + 1;
        if (n_sel < NUM_ACTIVE) begin
          target[k] = 1'b1;
          n_sel     = n_sel + 1;
        end
      end
    end
    for (int k = 0; k < NUM_REPLICAS; k++) begin
      if (faulty_q[k] && n_sel < NUM_ACTIVE) begin
        target[k] = 1'b1;
        n_sel     = n_sel + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REPLICAS; k++) cnt_q[k] <= '0;
      faulty_q   <= '0;
      degraded_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REPLICAS; k++) cnt_q[k] <= cnt_d[k];
      faulty_q   <= faulty_d;
      degraded_q <= (n_healthy < NUM_ACTIVE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      mask_q  <= RST_MASK;
    end else begin
      case (state_q)
        IDLE: begin
          if (target != mask_q) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (bus.reconfig_ack_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            mask_q  <= target;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reconfig_req_o     = req_q;
  assign bus.active_mask_o      = mask_q;
  assign bus.permanent_faulty_o = faulty_q;
  assign bus.degraded_o         = degraded_q;

endmodule

// File: tb/tb_cv32e40p_replica_fault_manager.sv
// Directed and random stimulus for the replica fault manager, checked against
// an index-list reference model of the selection and counting rules.
module tb_cv32e40p_replica_fault_manager;
  localparam int NR  = 4;
  localparam int NA  = 3;
  localparam int THR = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  cv32e40p_replica_fault_manager_if #(.NUM_REPLICAS(NR)) bus ();

  cv32e40p_replica_fault_manager #(
    .NUM_REPLICAS(NR), .NUM_ACTIVE(NA), .FAULT_THRESHOLD(THR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  int         m_cnt [NR];
  logic [3:0] m_faulty, m_mask;
  logic       m_req, m_deg, m_waiting;

  function automatic logic [3:0] ref_target(input logic [3:0] f);
    int order[$];
    logic [3:0] t;
    t = 4'b0;
    for (int k = 0; k < NR; k++) if (!f[k]) order.push_back(k);
    for (int k = 0; k < NR; k++) if (f[k]) order.push_back(k);
    for (int i = 0; i < NA; i++) t[order[i]] = 1'b1;
    return t;
  endfunction

  function automatic int n_healthy(input logic [3:0] f);
    int n = 0;
    for (int k = 0; k < NR; k++) if (!f[k]) n++;
    return n;
  endfunction

  task automatic model_update(input logic v, input logic [3:0] mm, input logic a, input logic r);
    logic [3:0] tgt, fnew;
    if (r) begin
      for (int k = 0; k < NR; k++) m_cnt[k] = 0;
      m_faulty = 4'b0; m_mask = 4'b0111; m_req = 1'b0; m_deg = 1'b0; m_waiting = 1'b0;
      return;
    end
    tgt  = ref_target(m_faulty);
    fnew = m_faulty;
    for (int k = 0; k < NR; k++) begin
      if (v && m_mask[k] && mm[k]) m_cnt[k] = (m_cnt[k] + 1 > THR) ? THR : m_cnt[k] + 1;
`ifdef CV32E40P_FAULT_DECAY_EN
      else if (v && m_mask[k] && m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
`endif
      if (m_cnt[k] == THR) fnew[k] = 1'b1;
    end
    m_deg = (n_healthy(m_faulty) < NA);
    if (m_waiting) begin
      if (a) begin m_mask = tgt; m_req = 1'b0; m_waiting = 1'b0; end
    end else if (tgt != m_mask) begin
      m_waiting = 1'b1; m_req = 1'b1;
    end
    m_faulty = fnew;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] mm, input logic a, input logic r);
    bus.valid_i = v; bus.mismatch_i = mm; bus.reconfig_ack_i = a; rst = r;
    @(posedge clk);
    model_update(v, mm, a, r);
    #1;
    chk("model_req",      {3'b0, bus.reconfig_req_o}, {3'b0, m_req});
    chk("model_mask",     bus.active_mask_o,          m_mask);
    chk("model_faulty",   bus.permanent_faulty_o,     m_faulty);
    chk("model_degraded", {3'b0, bus.degraded_o},     {3'b0, m_deg});
  endtask

  initial begin
    bus.valid_i = 1'b0; bus.mismatch_i = 4'b0; bus.reconfig_ack_i = 1'b0;
    m_faulty = 4'b0; m_mask = 4'b0111; m_req = 1'b0; m_deg = 1'b0; m_waiting = 1'b0;
    for (int k = 0; k < NR; k++) m_cnt[k] = 0;

    // reset
    step(0, 4'b0, 0, 1);
    step(0, 4'b0, 0, 1);
    chk("rst_mask", bus.active_mask_o, 4'b0111);
    chk("rst_faulty", bus.permanent_faulty_o, 4'b0000);
    chk("rst_req", {3'b0, bus.reconfig_req_o}, 4'b0);
    chk("rst_degraded", {3'b0, bus.degraded_o}, 4'b0);

    // inactive spare 3 is ignored
    for (int i = 0; i < 20; i++) step(1, 4'b1000, 0, 0);
    step(0, 4'b0, 0, 0);
    chk("spare_faulty", bus.permanent_faulty_o, 4'b0000);
    chk("spare_req", {3'b0, bus.reconfig_req_o}, 4'b0);

    // replica 0 latches, ack after 5 cycles
    for (int i = 0; i < 8; i++) step(1, 4'b0001, 0, 0);
    chk("r0_faulty", bus.permanent_faulty_o, 4'b0001);
    chk("r0_req_not_yet", {3'b0, bus.reconfig_req_o}, 4'b0);
    for (int i = 0; i < 5; i++) begin
      step(0, 4'b0, 0, 0);
      chk("r0_req_held", {3'b0, bus.reconfig_req_o}, 4'b1);
      chk("r0_mask_held", bus.active_mask_o, 4'b0111);
    end
    step(0, 4'b0, 1, 0);
    chk("r0_mask_switch", bus.active_mask_o, 4'b1110);
    chk("r0_req_drop", {3'b0, bus.reconfig_req_o}, 4'b0);

    // replica 1 then replica 2 latch before a single ack
    for (int i = 0; i < 8; i++) step(1, 4'b0010, 0, 0);
    chk("r1_faulty", bus.permanent_faulty_o, 4'b0011);
    step(0, 4'b0, 0, 0);
    chk("r1_req", {3'b0, bus.reconfig_req_o}, 4'b1);
    for (int i = 0; i < 8; i++) step(1, 4'b0100, 0, 0);
    chk("r2_faulty", bus.permanent_faulty_o, 4'b0111);
    step(0, 4'b0, 1, 0);
    chk("pad_mask", bus.active_mask_o, 4'b1011);
    chk("pad_degraded", {3'b0, bus.degraded_o}, 4'b1);
    step(0, 4'b0, 0, 0);
    chk("pad_no_rereq", {3'b0, bus.reconfig_req_o}, 4'b0);

    // rst abandons a pending request and clears counters
    step(0, 4'b0, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 4'b0011, 0, 0);
    step(1, 4'b0010, 0, 0);
    step(0, 4'b0, 0, 0);
    chk("mid_req", {3'b0, bus.reconfig_req_o}, 4'b1);
    step(0, 4'b0, 1, 1);
    chk("mid_rst_req", {3'b0, bus.reconfig_req_o}, 4'b0);
    chk("mid_rst_mask", bus.active_mask_o, 4'b0111);
    chk("mid_rst_faulty", bus.permanent_faulty_o, 4'b0000);
    for (int i = 0; i < 7; i++) step(1, 4'b0001, 0, 0);
    step(0, 4'b0, 0, 0);
    chk("cnt_cleared", bus.permanent_faulty_o, 4'b0000);

    // alternating mismatch / match on replica 0
    step(0, 4'b0, 0, 1);
    for (int i = 0; i < 100; i++) begin
      step(1, (i % 2 == 0) ? 4'b0001 : 4'b0000, 0, 0);
`ifndef CV32E40P_FAULT_DECAY_EN
      if (i == 14) chk("alt_8th_latch", bus.permanent_faulty_o, 4'b0001);
`endif
    end
`ifdef CV32E40P_FAULT_DECAY_EN
    chk("alt_decay", bus.permanent_faulty_o, 4'b0000);
`else
    chk("alt_nodecay", bus.permanent_faulty_o, 4'b0001);
`endif

    // random traffic against the model
    step(0, 4'b0, 0, 1);
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 59) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
